// File: rtl/rw_register_bus_arbiter_pkg.sv
// Shared types and defaults for the register-bank bus arbiter.
// Holds the FSM state encoding, default widths and the address-width helper.
package rw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 8;

    // Index width for n items; never less than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rw_register_bus_arbiter_rr_arbiter_core.sv
// Combinational round-robin picker: the requester at ptr has the highest priority,
// then ptr+1 and so on with wrap-around.
module rr_arbiter_core
    import rw_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = addr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_req
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic [PTR_W-1:0]     offset;
    logic [PTR_W:0]       sum;
    logic [PTR_W:0]       sum_wrapped;

    // Rotate so the pointer's requester lands on bit 0.
    assign dbl_shift = {req, req} >> ptr;
    assign rot       = dbl_shift[NUM_REQ-1:0];
    assign any_req   = |req;

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = PTR_W'(k);
            end
        end
    end

    assign sum         = {1'b0, ptr} + {1'b0, offset};
    assign sum_wrapped = sum - NUM_REQ_W;
    assign winner_idx  = (sum >= NUM_REQ_W) ? sum_wrapped[PTR_W-1:0] : sum[PTR_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner[gi] = any_req && (winner_idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rw_register_bus_arbiter.sv
// Round-robin arbiter sharing a tri-stated register bank between requesters; every output registered.
// Build option RWARB_TURNAROUND_EN adds a strobe-free TURN cycle after each DONE.
module rw_register_bus_arbiter
    import rw_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    // May be widened beyond the bank so out-of-range indices can be presented.
    parameter int ADDR_WIDTH = addr_width(NUM_REGS)
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ-1:0]             ReqWrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  ReqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  ReqData,
    output logic [NUM_REQ-1:0]             Grant,
    output logic [NUM_REQ-1:0]             Done,
    output logic [DATA_WIDTH-1:0]          RdData,
    output logic [NUM_REGS-1:0]            RegRE,
    output logic [NUM_REGS-1:0]            RegWE,
    output logic [DATA_WIDTH-1:0]          RegDataIn,
    input  logic [DATA_WIDTH-1:0]          RegDataOut
);

    localparam int PTR_W = addr_width(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

    arb_state_t state_reg, state_next;
    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic                  write_reg, write_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [NUM_REQ-1:0]    grant_reg, grant_next;
    logic [NUM_REQ-1:0]    done_reg, done_next;
    logic [NUM_REGS-1:0]   re_reg, re_next;
    logic [NUM_REGS-1:0]   we_reg, we_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;
    logic [DATA_WIDTH-1:0] rd_data_reg, rd_data_next;

    logic [NUM_REQ-1:0]    winner;
    logic [PTR_W-1:0]      winner_idx;
    logic                  any_req;
    logic [NUM_REGS-1:0]   reg_hit;
    logic                  addr_ok;

    logic [ADDR_WIDTH-1:0] addr_chain [NUM_REQ+1];
    logic [DATA_WIDTH-1:0] data_chain [NUM_REQ+1];
    logic [NUM_REQ:0]      write_chain;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_core (
        .req        (Req),
        .ptr        (ptr_reg),
        .winner     (winner),
        .winner_idx (winner_idx),
        .any_req    (any_req)
    );

    // AND-OR select of the winner's request fields.
    assign addr_chain[0]  = '0;
    assign data_chain[0]  = '0;
    assign write_chain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign addr_chain[gi+1]  = addr_chain[gi] |
                (winner[gi] ? ReqAddr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0);
            assign data_chain[gi+1]  = data_chain[gi] |
                (winner[gi] ? ReqData[gi*DATA_WIDTH +: DATA_WIDTH] : '0);
            assign write_chain[gi+1] = write_chain[gi] | (winner[gi] & ReqWrite[gi]);
        end
        // Out-of-range addresses match no register, so no strobe fires.
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign reg_hit[gi] = (addr_chain[NUM_REQ] == ADDR_WIDTH'(gi));
        end
    endgenerate

    assign addr_ok = ({1'b0, addr_reg} < NUM_REGS_W);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (any_req) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_DONE;
`ifdef RWARB_TURNAROUND_EN
            ST_DONE:   state_next = ST_TURN;
`else
            ST_DONE:   state_next = ST_IDLE;
`endif
            ST_TURN:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned to the state being entered.
    always_comb begin
        grant_next   = '0;
        done_next    = '0;
        re_next      = '0;
        we_next      = '0;
        din_next     = din_reg;
        rd_data_next = rd_data_reg;
        ptr_next     = ptr_reg;
        write_next   = write_reg;
        addr_next    = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next = winner;
                    write_next = write_chain[NUM_REQ];
                    addr_next  = addr_chain[NUM_REQ];
                    ptr_next   = (winner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : winner_idx + PTR_W'(1);
                    if (write_chain[NUM_REQ]) begin
                        we_next  = reg_hit;
                        din_next = data_chain[NUM_REQ];
                    end else begin
                        re_next  = reg_hit;
                    end
                end
            end
            ST_ACCESS: begin
                grant_next = grant_reg;
                done_next  = grant_reg;
                if (!write_reg) begin
                    rd_data_next = addr_ok ? RegDataOut : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_reg     <= '0;
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            grant_reg   <= '0;
            done_reg    <= '0;
            re_reg      <= '0;
            we_reg      <= '0;
            din_reg     <= '0;
            rd_data_reg <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            write_reg   <= write_next;
            addr_reg    <= addr_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            re_reg      <= re_next;
            we_reg      <= we_next;
            din_reg     <= din_next;
            rd_data_reg <= rd_data_next;
        end
    end

    assign Grant     = grant_reg;
    assign Done      = done_reg;
    assign RegRE     = re_reg;
    assign RegWE     = we_reg;
    assign RegDataIn = din_reg;
    assign RdData    = rd_data_reg;

endmodule

// File: tb/tb_rw_register_bus_arbiter.sv
// Directed bench for rw_register_bus_arbiter with a behavioural register bank.
// Built with a 4-bit address so out-of-range indices can be presented.
module tb_rw_register_bus_arbiter;

    localparam int NQ = 4;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;
`ifdef RWARB_TURNAROUND_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 3;
`endif

    logic             Clk = 1'b0;
    logic             Reset;
    logic [NQ-1:0]    Req;
    logic [NQ-1:0]    ReqWrite;
    logic [NQ*AW-1:0] ReqAddr;
    logic [NQ*DW-1:0] ReqData;
    logic [NQ-1:0]    Grant;
    logic [NQ-1:0]    Done;
    logic [DW-1:0]    RdData;
    logic [NR-1:0]    RegRE;
    logic [NR-1:0]    RegWE;
    logic [DW-1:0]    RegDataIn;
    logic [DW-1:0]    RegDataOut;

    logic [DW-1:0]    bank [NR];
    int checks = 0;
    int passed = 0;

    always #5 Clk = ~Clk;

    rw_register_bus_arbiter #(
        .NUM_REQ    (NQ),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .ReqData    (ReqData),
        .Grant      (Grant),
        .Done       (Done),
        .RdData     (RdData),
        .RegRE      (RegRE),
        .RegWE      (RegWE),
        .RegDataIn  (RegDataIn),
        .RegDataOut (RegDataOut)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hA0A0_0000 + 32'(a);
    endfunction

    always @(posedge Clk) begin
        for (int i = 0; i < NR; i++) begin
            if (Reset) bank[i] <= init_val(i);
            else if (RegWE[i]) bank[i] <= RegDataIn;
        end
    end

    // Enabled registers OR onto the bus, so contention would corrupt read data.
    always_comb begin
        RegDataOut = '0;
        for (int i = 0; i < NR; i++) begin
            if (RegRE[i]) RegDataOut = RegDataOut | bank[i];
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Req[idx] = 1'b1;
        ReqWrite[idx] = wr;
        ReqAddr[idx*AW +: AW] = a;
        ReqData[idx*DW +: DW] = d;
    endtask

    task automatic idle_gap;
        Req = '0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Req = '0; ReqWrite = '0; ReqAddr = '0; ReqData = '0;
        tick;
        tick;
        checks++; if (Grant !== 4'h0) $display("FAIL reset_grant: got %b need 0000", Grant); else passed++;
        checks++; if (Done !== 4'h0) $display("FAIL reset_done: got %b need 0000", Done); else passed++;
        checks++; if (RegRE !== 8'h00) $display("FAIL reset_re: got %b need 0", RegRE); else passed++;
        checks++; if (RegWE !== 8'h00) $display("FAIL reset_we: got %b need 0", RegWE); else passed++;
        checks++; if (RegDataIn !== 32'h0) $display("FAIL reset_din: got %h need 0", RegDataIn); else passed++;
        checks++; if (RdData !== 32'h0) $display("FAIL reset_rddata: got %h need 0", RdData); else passed++;
        Reset = 1'b0;
        tick;
        checks++; if (Grant !== 4'h0) $display("FAIL idle_grant: got %b need 0000", Grant); else passed++;
        $display("txn reset complete");
    endtask

    task automatic test_write_read;
        set_req(0, 1'b1, 4'd3, 32'h0011_2233);
        tick;
        checks++; if (RegWE !== 8'h08) $display("FAIL wr_we: got %b need 00001000", RegWE); else passed++;
        checks++; if (RegRE !== 8'h00) $display("FAIL wr_re: got %b need 0", RegRE); else passed++;
        checks++; if (Grant !== 4'b0001) $display("FAIL wr_grant: got %b need 0001", Grant); else passed++;
        checks++; if (RegDataIn !== 32'h0011_2233) $display("FAIL wr_din: got %h need 00112233", RegDataIn); else passed++;
        tick;
        checks++; if (Done !== 4'b0001) $display("FAIL wr_done: got %b need 0001", Done); else passed++;
        checks++; if (RegWE !== 8'h00) $display("FAIL wr_we_off: got %b need 0", RegWE); else passed++;
        checks++; if (Grant !== 4'b0001) $display("FAIL wr_grant_done: got %b need 0001", Grant); else passed++;
        $display("txn write req0 addr3 data 00112233");
        idle_gap;
        set_req(0, 1'b0, 4'd3, 32'h0);
        tick;
        checks++; if (RegRE !== 8'h08) $display("FAIL rd_re: got %b need 00001000", RegRE); else passed++;
        checks++; if (RegWE !== 8'h00) $display("FAIL rd_we: got %b need 0", RegWE); else passed++;
        checks++; if (RegDataIn !== 32'h0011_2233) $display("FAIL rd_din_hold: got %h need 00112233", RegDataIn); else passed++;
        tick;
        checks++; if (Done !== 4'b0001) $display("FAIL rd_done: got %b need 0001", Done); else passed++;
        checks++; if (RdData !== 32'h0011_2233) $display("FAIL rd_data: got %h need 00112233", RdData); else passed++;
        $display("txn read req0 addr3 data %h", RdData);
        idle_gap;
    endtask

    task automatic test_round_robin;
        int n = 0;
        int last = -1;
        int c = 0;
        logic [NQ-1:0] exp_g;
        logic [NR-1:0] exp_re;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        checks++; if (RdData !== 32'h0) $display("FAIL rr_reset_rddata: got %h need 0", RdData); else passed++;
        checks++; if (RegDataIn !== 32'h0) $display("FAIL rr_reset_din: got %h need 0", RegDataIn); else passed++;
        for (int i = 0; i < NQ; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        while (n < 5 && c < 40) begin
            tick;
            c++;
            if (RegRE !== 8'h00) begin
                exp_g  = 4'b0001 << (n % 4);
                exp_re = 8'h01 << (n % 4);
                checks++; if (Grant !== exp_g) $display("FAIL rr_grant%0d: got %b need %b", n, Grant, exp_g); else passed++;
                checks++; if (RegRE !== exp_re) $display("FAIL rr_re%0d: got %b need %b", n, RegRE, exp_re); else passed++;
                if (last >= 0) begin
                    checks++; if (c - last != PERIOD) $display("FAIL rr_period%0d: got %0d need %0d", n, c - last, PERIOD); else passed++;
                end
                last = c;
                tick;
                c++;
                checks++; if (Done !== exp_g) $display("FAIL rr_done%0d: got %b need %b", n, Done, exp_g); else passed++;
                checks++; if (RdData !== init_val(n % 4)) $display("FAIL rr_data%0d: got %h need %h", n, RdData, init_val(n % 4)); else passed++;
                $display("txn rr grant %0d to req%0d data %h", n, n % 4, RdData);
                n++;
            end
        end
        if (n < 5) begin
            checks++;
            $display("FAIL rr_timeout: got %0d grants need 5", n);
        end
        idle_gap;
    endtask

    task automatic test_latency;
        set_req(2, 1'b1, 4'd5, 32'hCAFE_0005);
        tick;
        checks++; if (RegWE !== 8'h20) $display("FAIL lat_we: got %b need 00100000", RegWE); else passed++;
        checks++; if (RegRE !== 8'h00) $display("FAIL lat_re: got %b need 0", RegRE); else passed++;
        checks++; if (Grant !== 4'b0100) $display("FAIL lat_grant: got %b need 0100", Grant); else passed++;
        tick;
        checks++; if (Done !== 4'b0100) $display("FAIL lat_done: got %b need 0100", Done); else passed++;
        checks++; if ((RegRE | RegWE) !== 8'h00) $display("FAIL lat_strobes_off: got %b need 0", RegRE | RegWE); else passed++;
        $display("txn write req2 addr5 data cafe0005");
        idle_gap;
    endtask

    task automatic test_reset_mid;
        set_req(1, 1'b1, 4'd1, 32'h1111_2222);
        tick;
        checks++; if (RegWE !== 8'h02) $display("FAIL rst_mid_we: got %b need 00000010", RegWE); else passed++;
        Reset = 1'b1;
        Req = '0;
        tick;
        checks++; if ((RegRE | RegWE) !== 8'h00) $display("FAIL rst_mid_strobes: got %b need 0", RegRE | RegWE); else passed++;
        checks++; if (Grant !== 4'h0) $display("FAIL rst_mid_grant: got %b need 0000", Grant); else passed++;
        checks++; if (Done !== 4'h0) $display("FAIL rst_mid_done: got %b need 0000", Done); else passed++;
        Reset = 1'b0;
        tick;
        checks++; if (Done !== 4'h0) $display("FAIL rst_mid_no_done: got %b need 0000", Done); else passed++;
        for (int i = 0; i < NQ; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        tick;
        checks++; if (Grant !== 4'b0001) $display("FAIL rst_mid_ptr: got %b need 0001", Grant); else passed++;
        checks++; if (RegRE !== 8'h01) $display("FAIL rst_mid_re: got %b need 00000001", RegRE); else passed++;
        Req = '0;
        tick;
        checks++; if (Done !== 4'b0001) $display("FAIL rst_mid_drop_done: got %b need 0001", Done); else passed++;
        checks++; if (RdData !== init_val(0)) $display("FAIL rst_mid_data: got %h need %h", RdData, init_val(0)); else passed++;
        $display("txn abandoned write req1, then read req0 data %h", RdData);
        idle_gap;
    endtask

    task automatic test_bad_addr;
        set_req(0, 1'b0, 4'd9, 32'h0);
        tick;
        checks++; if ((RegRE | RegWE) !== 8'h00) $display("FAIL bad_strobes: got %b need 0", RegRE | RegWE); else passed++;
        checks++; if (Grant !== 4'b0001) $display("FAIL bad_grant: got %b need 0001", Grant); else passed++;
        tick;
        checks++; if (Done !== 4'b0001) $display("FAIL bad_done: got %b need 0001", Done); else passed++;
        checks++; if (RdData !== 32'h0) $display("FAIL bad_rddata: got %h need 0", RdData); else passed++;
        $display("txn read req0 addr9 data %h", RdData);
        idle_gap;
    endtask

    task automatic test_pulse_ignored;
        set_req(0, 1'b0, 4'd2, 32'h0);
        tick;
        checks++; if (Grant !== 4'b0001) $display("FAIL pulse_grant: got %b need 0001", Grant); else passed++;
        checks++; if (RegRE !== 8'h04) $display("FAIL pulse_re: got %b need 00000100", RegRE); else passed++;
        set_req(1, 1'b0, 4'd3, 32'h0);
        tick;
        Req = '0;
        checks++; if (Done !== 4'b0001) $display("FAIL pulse_done0: got %b need 0001", Done); else passed++;
        checks++; if (RdData !== init_val(2)) $display("FAIL pulse_data: got %h need %h", RdData, init_val(2)); else passed++;
        $display("txn read req0 addr2 data %h", RdData);
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++; if (Grant !== 4'h0) $display("FAIL pulse_grant_idle%0d: got %b need 0000", k, Grant); else passed++;
            checks++; if (Done !== 4'h0) $display("FAIL pulse_done_idle%0d: got %b need 0000", k, Done); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_read;
        test_round_robin;
        test_latency;
        test_reset_mid;
        test_bad_addr;
        test_pulse_ignored;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
